axis_modport: RTL and testbench

- AXI4-Stream pass-through stage between one stream master and one stream slave.
- Full-throughput two-entry register slice (skid buffer) that registers every forward and backward signal.
- Includes a sticky protocol checker on the upstream (slave) side and beat/packet counters.
- Placed between a stream master agent/DUT and the interconnect so that both sides see clean, registered AXIS timing.

---
 rtl/axis_modport.sv | 205 ++++++++++++++++++++
 tb/tb_axis_modport.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_modport.sv
// -----------------------------------------------------------------------------
// axis_modport
//
// AXI4-Stream pass-through stage. It sits between one stream master and one
// stream slave and registers every forward and backward signal.
//
// Data path: a two-entry register slice (skid buffer).
//   - The main output register drives M_*.
//   - One skid register catches a beat that was accepted while the output
//     register was full and stalled.
//   - S_TREADY comes straight from a flop and means "skid register empty".
//     Because of this, no combinational path runs from M_TREADY to S_TREADY.
//
// Side functions:
//   - Sticky upstream protocol checker (err_stable, err_strb).
//   - Downstream beat and packet counters (beat_cnt, pkt_cnt).
//
// Ports:
//   ACLK, ARESETn    clock (rising edge); asynchronous active-low reset
//   S_T*             upstream payload, S_TVALID in, S_TREADY out
//   M_T*             downstream payload, M_TVALID out, M_TREADY in
//   err_stable       sticky: upstream dropped TVALID or changed payload while
//                    stalled
//   err_strb         sticky: an accepted upstream beat had TSTRB[i]=1 with
//                    TKEEP[i]=0
//   beat_cnt         downstream handshakes (M_TVALID & M_TREADY), wraps
//   pkt_cnt          downstream handshakes with M_TLAST=1, wraps
//
// Handshake semantics (both sides):
//   A beat transfers on a rising edge where TVALID and TREADY are both 1.
//   Once the source raises TVALID, it must hold TVALID and the payload stable
//   until that transfer occurs. The sink may change TREADY freely.
//   This block honours the rule on the M side. It checks, but does not
//   enforce, the rule on the S side.
// -----------------------------------------------------------------------------
module axis_modport #(
    parameter int NUMBER_BYTES = 4,
    parameter int ID_W         = 8,
    parameter int DEST_W       = 4,
    parameter int USER_W       = 17,
    parameter int CNT_W        = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      S_TVALID,
    input  logic [8*NUMBER_BYTES-1:0] S_TDATA,
    input  logic [NUMBER_BYTES-1:0]   S_TSTRB,
    input  logic [NUMBER_BYTES-1:0]   S_TKEEP,
    input  logic                      S_TLAST,
    input  logic [ID_W-1:0]           S_TID,
    input  logic [DEST_W-1:0]         S_TDEST,
    input  logic [USER_W-1:0]         S_TUSER,
    output logic                      S_TREADY,

    output logic                      M_TVALID,
    output logic [8*NUMBER_BYTES-1:0] M_TDATA,
    output logic [NUMBER_BYTES-1:0]   M_TSTRB,
    output logic [NUMBER_BYTES-1:0]   M_TKEEP,
    output logic                      M_TLAST,
    output logic [ID_W-1:0]           M_TID,
    output logic [DEST_W-1:0]         M_TDEST,
    output logic [USER_W-1:0]         M_TUSER,
    input  logic                      M_TREADY,

    output logic                      err_stable,
    output logic                      err_strb,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic [CNT_W-1:0]          pkt_cnt
);

    localparam int DATA_W = 8 * NUMBER_BYTES;
    localparam int PAY_W  = DATA_W + 2 * NUMBER_BYTES + 1 + ID_W + DEST_W + USER_W;

    // All payload fields travel as one packed word, so they can never be
    // separated or reordered relative to each other.
    logic [PAY_W-1:0] s_payload;

    logic [PAY_W-1:0] out_q;
    logic [PAY_W-1:0] out_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [PAY_W-1:0] skid_q;
    logic [PAY_W-1:0] skid_d;
    logic             skid_valid_q;
    logic             skid_valid_d;

    logic             s_ready_q;
    logic             s_accept;
    logic             m_drain;

    logic             stall_q;
    logic [PAY_W-1:0] stall_pay_q;
    logic             err_stable_q;
    logic             err_strb_q;
    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] pkt_q;

    assign s_payload = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};

    assign s_accept = S_TVALID & s_ready_q;
    assign m_drain  = out_valid_q & M_TREADY;

    // ------------------------------------------------------------------
    // Slice next-state.
    // The output register can take a new beat when it is empty or is being
    // drained this cycle. When the skid register is full it always refills
    // the output first. In that state s_ready_q is 0, so no upstream beat
    // can arrive in the same cycle.
    // A beat that arrives while the output register is stalled goes into
    // the skid register.
    // ------------------------------------------------------------------
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (!out_valid_q || m_drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (s_accept) begin
                out_d       = s_payload;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (s_accept) begin
            skid_d       = s_payload;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            // Ready is the registered "skid empty" of the next state.
            // It is 0 during reset and rises on the first edge after release.
            s_ready_q    <= ~skid_valid_d;
        end
    end

    assign S_TREADY = s_ready_q;
    assign M_TVALID = out_valid_q;
    assign {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER} = out_q;

    // ------------------------------------------------------------------
    // Upstream protocol checker. It watches only and never feeds the data
    // path.
    // stall_q records that the previous edge saw S_TVALID=1 with S_TREADY=0.
    // On the following edge, the source must still be valid and must present
    // the identical payload.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stall_q      <= 1'b0;
            stall_pay_q  <= '0;
            err_stable_q <= 1'b0;
            err_strb_q   <= 1'b0;
        end else begin
            stall_q     <= S_TVALID & ~s_ready_q;
            stall_pay_q <= s_payload;
            if (stall_q && (!S_TVALID || (s_payload != stall_pay_q))) begin
                err_stable_q <= 1'b1;
            end
            if (s_accept && ((S_TSTRB & ~S_TKEEP) != '0)) begin
                err_strb_q <= 1'b1;
            end
        end
    end

    assign err_stable = err_stable_q;
    assign err_strb   = err_strb_q;

    // ------------------------------------------------------------------
    // Downstream counters. Both wrap naturally at 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat_q <= '0;
            pkt_q  <= '0;
        end else if (m_drain) begin
            beat_q <= beat_q + CNT_W'(1);
            if (M_TLAST) begin
                pkt_q <= pkt_q + CNT_W'(1);
            end
        end
    end

    assign beat_cnt = beat_q;
    assign pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_axis_modport.sv
// -----------------------------------------------------------------------------
// tb_axis_modport
//
// Testbench for axis_modport.
//
// Reference model: a queue holding every beat that is inside the slice.
//   - A beat is pushed when an upstream handshake is due at the next edge.
//   - A beat is popped when a downstream handshake is due at the next edge.
//   - From the queue depth alone, the model predicts M_TVALID (depth >= 1),
//     S_TREADY (depth <= 1), the M_* payload (queue head) and both counters.
//
// Timing: inputs change 1 time unit after each rising edge. Outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_modport;

  localparam int NB       = 4;
  localparam int ID_W     = 8;
  localparam int DEST_W   = 4;
  localparam int USER_W   = 17;
  localparam int CNT_W    = 32;
  localparam int DW       = 8 * NB;
  localparam int PW       = DW + 2 * NB + 1 + ID_W + DEST_W + USER_W;
  localparam int LAST_BIT = ID_W + DEST_W + USER_W;

  // ---------------- clock / reset ----------------
  logic ACLK;
  logic ARESETn;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- DUT signals ----------------
  logic              S_TVALID;
  logic [DW-1:0]     S_TDATA;
  logic [NB-1:0]     S_TSTRB;
  logic [NB-1:0]     S_TKEEP;
  logic              S_TLAST;
  logic [ID_W-1:0]   S_TID;
  logic [DEST_W-1:0] S_TDEST;
  logic [USER_W-1:0] S_TUSER;
  logic              S_TREADY;
  logic              M_TVALID;
  logic [DW-1:0]     M_TDATA;
  logic [NB-1:0]     M_TSTRB;
  logic [NB-1:0]     M_TKEEP;
  logic              M_TLAST;
  logic [ID_W-1:0]   M_TID;
  logic [DEST_W-1:0] M_TDEST;
  logic [USER_W-1:0] M_TUSER;
  logic              M_TREADY;
  logic              err_stable;
  logic              err_strb;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  pkt_cnt;

  axis_modport #(
    .NUMBER_BYTES(NB), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W), .CNT_W(CNT_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_TVALID(S_TVALID), .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB), .S_TKEEP(S_TKEEP),
    .S_TLAST(S_TLAST), .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
    .S_TREADY(S_TREADY),
    .M_TVALID(M_TVALID), .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB), .M_TKEEP(M_TKEEP),
    .M_TLAST(M_TLAST), .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
    .M_TREADY(M_TREADY),
    .err_stable(err_stable), .err_strb(err_strb),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt)
  );

  logic [PW-1:0] s_pay;
  logic [PW-1:0] m_pay;
  assign s_pay = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};
  assign m_pay = {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER};

  // ---------------- scoreboard ----------------
  int               n_vec;
  int               n_err;
  logic [PW-1:0]    exp_q[$];
  logic [CNT_W-1:0] mdl_beats;
  logic [CNT_W-1:0] mdl_pkts;
  logic             live;  // at least one rising edge seen since reset release

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Check the DUT against the queue model on every falling edge.
  // Then apply the handshakes that the next rising edge will perform.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_q.delete();
      mdl_beats = '0;
      mdl_pkts  = '0;
      check("rst_m_tvalid", M_TVALID, 0);
      check("rst_s_tready", S_TREADY, 0);
      check("rst_m_payload", m_pay, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_errs", {err_stable, err_strb}, 0);
    end else begin
      check("s_tready", S_TREADY, live && (exp_q.size() <= 1));
      check("m_tvalid", M_TVALID, exp_q.size() != 0);
      if (exp_q.size() != 0) check("m_payload", m_pay, exp_q[0]);
      check("beat_cnt", beat_cnt, mdl_beats);
      check("pkt_cnt", pkt_cnt, mdl_pkts);
      if (M_TVALID && M_TREADY && exp_q.size() != 0) begin
        mdl_beats = mdl_beats + 1'b1;
        if (exp_q[0][LAST_BIT]) mdl_pkts = mdl_pkts + 1'b1;
        void'(exp_q.pop_front());
      end
      if (S_TVALID && S_TREADY) exp_q.push_back(s_pay);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic put(input logic v, input logic [DW-1:0] d, input logic l,
                     input logic [NB-1:0] s, input logic [NB-1:0] k);
    S_TVALID = v;
    S_TDATA  = d;
    S_TLAST  = l;
    S_TSTRB  = s;
    S_TKEEP  = k;
    S_TID    = 8'h3c;
    S_TDEST  = 4'h9;
    S_TUSER  = 17'h1a5a5;
  endtask

  // One random cycle. A stalled beat is held unchanged, so the source stays
  // compliant with the handshake rules.
  task automatic step_rand(input int p_valid, input int p_ready);
    logic held;
    logic [NB-1:0] k;
    @(negedge ACLK);
    held = S_TVALID && !S_TREADY;
    @(posedge ACLK);
    #1;
    if (!held) begin
      k        = NB'($urandom);
      S_TVALID = ($urandom_range(99) < p_valid);
      S_TDATA  = DW'($urandom);
      S_TKEEP  = k;
      S_TSTRB  = k & NB'($urandom);
      S_TLAST  = ($urandom_range(3) == 0);
      S_TID    = ID_W'($urandom);
      S_TDEST  = DEST_W'($urandom);
      S_TUSER  = USER_W'($urandom);
    end
    M_TREADY = ($urandom_range(99) < p_ready);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    mdl_beats = '0;
    mdl_pkts  = '0;
    ARESETn   = 1'b0;
    M_TREADY  = 1'b0;
    put(1'b0, '0, 1'b0, '0, '0);

    // Reset release with S_TVALID=0.
    tick(); tick(); tick();
    check("in_reset_s_tready", S_TREADY, 0);
    ARESETn = 1'b1;
    #1;
    check("pre_edge_s_tready", S_TREADY, 0);
    tick();
    check("post_rel_s_tready", S_TREADY, 1);
    check("post_rel_m_tvalid", M_TVALID, 0);
    tick();
    check("idle_m_tvalid", M_TVALID, 0);

    // Streaming: four beats, TLAST on the fourth, M_TREADY held at 1.
    M_TREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, DW'(8'h11 * (i + 1)), (i == 3), 4'hf, 4'hf);
      tick();
      check("stream_m_tvalid", M_TVALID, 1);
      check("stream_m_tdata", M_TDATA, DW'(8'h11 * (i + 1)));
    end
    put(1'b0, '0, 1'b0, '0, '0);
    tick();
    check("stream_end_m_tvalid", M_TVALID, 0);
    check("stream_beat_cnt", beat_cnt, 4);
    check("stream_pkt_cnt", pkt_cnt, 1);

    // Backpressure: three beats offered with M_TREADY=0.
    M_TREADY = 1'b0;
    put(1'b1, 32'ha1, 1'b0, 4'hf, 4'hf);
    tick();
    check("bp_ready_after1", S_TREADY, 1);
    put(1'b1, 32'ha2, 1'b0, 4'hf, 4'hf);
    tick();
    check("bp_ready_after2", S_TREADY, 0);
    check("bp_hold_data", M_TDATA, 32'ha1);
    put(1'b1, 32'ha3, 1'b0, 4'hf, 4'hf);
    tick();
    tick();
    check("bp_stall_ready", S_TREADY, 0);
    check("bp_stall_data", M_TDATA, 32'ha1);
    M_TREADY = 1'b1;
    tick();
    check("bp_drain_a2", M_TDATA, 32'ha2);
    check("bp_ready_back", S_TREADY, 1);
    tick();
    check("bp_drain_a3", M_TDATA, 32'ha3);
    put(1'b0, '0, 1'b0, '0, '0);
    tick();
    check("bp_empty_m_tvalid", M_TVALID, 0);
    check("bp_beat_cnt", beat_cnt, 7);
    check("bp_err_stable", err_stable, 0);

    // Strobe violation: TSTRB bit set where TKEEP is clear.
    put(1'b1, 32'h5a, 1'b1, 4'hf, 4'he);
    tick();
    put(1'b0, '0, 1'b0, '0, '0);
    check("strb_err", err_strb, 1);
    check("strb_fwd_data", M_TDATA, 32'h5a);
    check("strb_fwd_strb_keep", {M_TSTRB, M_TKEEP}, 8'hfe);
    tick();
    tick();
    check("strb_err_sticky", err_strb, 1);
    check("strb_pkt_cnt", pkt_cnt, 2);

    // Stability violation: payload changes while the source is stalled.
    M_TREADY = 1'b0;
    put(1'b1, 32'hb1, 1'b0, 4'hf, 4'hf);
    tick();
    put(1'b1, 32'hb2, 1'b0, 4'hf, 4'hf);
    tick();
    put(1'b1, 32'hb3, 1'b0, 4'hf, 4'hf);
    tick();
    check("stab_before", err_stable, 0);
    put(1'b1, 32'hb4, 1'b0, 4'hf, 4'hf);
    tick();
    check("stab_err", err_stable, 1);
    tick();
    tick();
    check("stab_err_sticky", err_stable, 1);
    check("stab_skid_full", {M_TVALID, S_TREADY}, 2'b10);

    // Reset mid-stall, asserted between edges.
    #2;
    ARESETn = 1'b0;
    #1;
    check("midrst_m_tvalid", M_TVALID, 0);
    check("midrst_s_tready", S_TREADY, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_errs", {err_stable, err_strb}, 0);
    put(1'b0, '0, 1'b0, '0, '0);
    tick();
    tick();
    ARESETn = 1'b1;
    tick();
    check("midrst_rel_s_tready", S_TREADY, 1);

    // Random traffic under a mix of upstream rates and downstream readiness.
    for (int i = 0; i < 600; i++) step_rand(70, 60);
    for (int i = 0; i < 600; i++) step_rand(95, 95);
    for (int i = 0; i < 600; i++) step_rand(40, 20);

    // Drain everything still inside the slice.
    for (int i = 0; i < 50 && (exp_q.size() != 0 || S_TVALID); i++) step_rand(0, 100);
    tick();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_m_tvalid", M_TVALID, 0);
    check("rand_errs", {err_stable, err_strb}, 0);
    check("rand_beat_cnt", beat_cnt, mdl_beats);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
